// File: rtl/bsg_link_pearl_pkg.sv
// Shared types and helpers for the SDR link pearl and its core-side packet assembler.
package bsg_link_pearl_pkg;

  // Assembler FSM: waiting for header, collecting payload, holding a finished packet.
  typedef enum logic [1:0] {
    PKT_ASM_IDLE = 2'd0,
    PKT_ASM_BODY = 2'd1,
    PKT_ASM_DONE = 2'd2
  } bsg_sdr_link_pkt_asm_state_e;

  // Length field sits in the low bits of the header flit.
  localparam int PKT_ASM_HDR_LEN_LSB = 0;

  // clog2 that never returns 0, so a 1-entry structure still gets a 1-bit index.
  function automatic int safe_clog2(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/bsg_sdr_link_packet_assembler.sv
// Reassembles header + N payload flits from the SDR link into one wide,
// zero-padded packet. Holds a single packet; the flit side stalls while it is held.
module bsg_sdr_link_packet_assembler
  import bsg_link_pearl_pkg::*;
#(
  parameter int flit_width_p        = 16,
  parameter int max_payload_flits_p = 4,
  parameter int len_width_p         = safe_clog2(max_payload_flits_p + 1)
) (
  input  logic                                      core_clk_i,
  input  logic                                      core_reset_n_i,
  input  logic [flit_width_p-1:0]                   flit_data_i,
  input  logic                                      flit_v_i,
  output logic                                      flit_ready_and_o,
  output logic [flit_width_p-1:0]                   pkt_header_o,
  output logic [max_payload_flits_p*flit_width_p-1:0] pkt_payload_o,
  output logic [len_width_p-1:0]                    pkt_len_o,
  output logic                                      pkt_v_o,
  input  logic                                      pkt_ready_and_i,
  output logic                                      len_err_o
);

  localparam int cnt_width_lp = safe_clog2(max_payload_flits_p);
  localparam logic [len_width_p-1:0] max_len_lp = len_width_p'(max_payload_flits_p);

  bsg_sdr_link_pkt_asm_state_e r_state, w_state_n;

  logic [flit_width_p-1:0]                          r_hdr;
  logic [max_payload_flits_p-1:0][flit_width_p-1:0] r_payload;
  logic [len_width_p-1:0]                           r_len;
  logic [cnt_width_lp-1:0]                          r_cnt;
  logic                                             r_len_err;

  logic [len_width_p-1:0] w_hdr_len;
  logic                   w_over;
  logic                   w_hdr_take;
  logic                   w_body_take;
  logic                   w_body_last;

  assign w_hdr_len   = flit_data_i[PKT_ASM_HDR_LEN_LSB +: len_width_p];
  assign w_over      = (w_hdr_len > max_len_lp);
  // cnt+1 == len marks the final payload flit; cnt therefore tops out at len-1.
  assign w_body_last = ((len_width_p'(r_cnt) + len_width_p'(1)) == r_len);

  // State register.
  always_ff @(posedge core_clk_i or negedge core_reset_n_i) begin
    if (!core_reset_n_i) r_state <= PKT_ASM_IDLE;
    else                 r_state <= w_state_n;
  end

  // Next state and handshake outputs; ready depends on registered state only.
  always_comb begin
    w_state_n        = r_state;
    flit_ready_and_o = 1'b0;
    pkt_v_o          = 1'b0;
    w_hdr_take       = 1'b0;
    w_body_take      = 1'b0;
    unique case (r_state)
      PKT_ASM_IDLE: begin
        flit_ready_and_o = 1'b1;
        if (flit_v_i) begin
          w_hdr_take = 1'b1;
          // An over-max length clamps to max, which is never 0.
          w_state_n  = (w_hdr_len == '0) ? PKT_ASM_DONE : PKT_ASM_BODY;
        end
      end
      PKT_ASM_BODY: begin
        flit_ready_and_o = 1'b1;
        if (flit_v_i) begin
          w_body_take = 1'b1;
          if (w_body_last) w_state_n = PKT_ASM_DONE;
        end
      end
      PKT_ASM_DONE: begin
        pkt_v_o = 1'b1;
        if (pkt_ready_and_i) w_state_n = PKT_ASM_IDLE;
      end
      default: w_state_n = PKT_ASM_IDLE;
    endcase
  end

  // Header, clamped length, payload counter and sticky length error.
  always_ff @(posedge core_clk_i or negedge core_reset_n_i) begin
    if (!core_reset_n_i) begin
      r_hdr     <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_len_err <= 1'b0;
    end else if (w_hdr_take) begin
      r_hdr <= flit_data_i;
      r_len <= w_over ? max_len_lp : w_hdr_len;
      r_cnt <= '0;
      if (w_over) r_len_err <= 1'b1;
    end else if (w_body_take) begin
      r_cnt <= r_cnt + cnt_width_lp'(1);
    end
  end

  // Payload slots: zeroed on each header so unused slots read as 0.
  always_ff @(posedge core_clk_i or negedge core_reset_n_i) begin
    if (!core_reset_n_i) begin
      r_payload <= '0;
    end else if (w_hdr_take) begin
      r_payload <= '0;
    end else if (w_body_take) begin
      for (int k = 0; k < max_payload_flits_p; k++)
        if (r_cnt == cnt_width_lp'(k)) r_payload[k] <= flit_data_i;
    end
  end

  assign pkt_header_o  = r_hdr;
  assign pkt_payload_o = r_payload;
  assign pkt_len_o     = r_len;
  assign len_err_o     = r_len_err;

endmodule

// File: tb/tb_bsg_sdr_link_packet_assembler.sv
// Directed and randomized-gap checks for the SDR link packet assembler.
module tb_bsg_sdr_link_packet_assembler;

  localparam int W = 16;
  localparam int M = 4;
  localparam int L = 3;

  logic           clk, rst_n;
  logic [W-1:0]   flit_data;
  logic           flit_v, flit_ready;
  logic [W-1:0]   hdr;
  logic [M*W-1:0] payload;
  logic [L-1:0]   len;
  logic           pkt_v, pkt_ready, len_err;

  int n_chk = 0;
  int n_err = 0;

  bsg_sdr_link_packet_assembler #(
    .flit_width_p(W), .max_payload_flits_p(M), .len_width_p(L)
  ) dut (
    .core_clk_i      (clk),
    .core_reset_n_i  (rst_n),
    .flit_data_i     (flit_data),
    .flit_v_i        (flit_v),
    .flit_ready_and_o(flit_ready),
    .pkt_header_o    (hdr),
    .pkt_payload_o   (payload),
    .pkt_len_o       (len),
    .pkt_v_o         (pkt_v),
    .pkt_ready_and_i (pkt_ready),
    .len_err_o       (len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle inputs/outputs 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [W-1:0]   h;
    logic [L-1:0]   n;
    logic [M*W-1:0] p;
  } pkt_t;

  pkt_t         exp_q[$];
  logic [W-1:0] flit_q[$];

  initial begin
    int cyc;
    logic fhs, phs;
    pkt_t e;

    flit_data = '0; flit_v = 1'b0; pkt_ready = 1'b0;
    rst_n = 1'b0;
    #12;
    chk("rst_pkt_v",   pkt_v,   0);
    chk("rst_hdr",     hdr,     0);
    chk("rst_payload", payload, 0);
    chk("rst_len",     len,     0);
    chk("rst_len_err", len_err, 0);
    rst_n = 1'b1;
    step();
    chk("idle_ready", flit_ready, 1);

    // Basic 3-flit packet, back-to-back.
    flit_v = 1'b1; flit_data = 16'hA003; step();
    flit_data = 16'h1111; step();
    flit_data = 16'h2222; step();
    chk("p3_not_yet", pkt_v, 0);
    flit_data = 16'h3333; step();
    chk("p3_v",       pkt_v, 1);
    chk("p3_len",     len, 3);
    chk("p3_payload", payload, 64'h0000_3333_2222_1111);
    chk("p3_hdr",     hdr, 16'hA003);

    // Held packet: flits offered but refused, outputs stable.
    flit_data = 16'hBEEF;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_ready",   flit_ready, 0);
      chk("hold_v",       pkt_v, 1);
      chk("hold_payload", payload, 64'h0000_3333_2222_1111);
    end
    pkt_ready = 1'b1; step();
    chk("rel_v",     pkt_v, 0);
    chk("rel_ready", flit_ready, 1);
    pkt_ready = 1'b0;

    // Zero-length packet; the offered header is accepted right after release.
    flit_data = 16'h0000; step();
    flit_v = 1'b0;
    chk("p0_v",       pkt_v, 1);
    chk("p0_len",     len, 0);
    chk("p0_payload", payload, 0);
    chk("p0_hdr",     hdr, 0);
    pkt_ready = 1'b1; step(); pkt_ready = 1'b0;

    // Over-max length: clamp to 4, 5th flit becomes next header.
    flit_v = 1'b1; flit_data = 16'h0007; step();
    chk("ovr_err", len_err, 1);
    for (int i = 1; i <= 4; i++) begin
      flit_data = W'(i); step();
    end
    flit_v = 1'b0;
    chk("ovr_v",       pkt_v, 1);
    chk("ovr_len",     len, 4);
    chk("ovr_payload", payload, 64'h0004_0003_0002_0001);
    pkt_ready = 1'b1; step(); pkt_ready = 1'b0;
    flit_v = 1'b1; flit_data = 16'h0001; step();
    flit_data = 16'h00AA; step();
    flit_v = 1'b0;
    chk("resync_v",       pkt_v, 1);
    chk("resync_hdr",     hdr, 16'h0001);
    chk("resync_payload", payload, 64'h00AA);
    chk("resync_err",     len_err, 1);
    pkt_ready = 1'b1; step(); pkt_ready = 1'b0;

    // Reset mid-packet.
    flit_v = 1'b1; flit_data = 16'h0002; step();
    flit_data = 16'h5555; step();
    flit_v = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_v",       pkt_v, 0);
    chk("mid_rst_hdr",     hdr, 0);
    chk("mid_rst_payload", payload, 0);
    chk("mid_rst_len",     len, 0);
    chk("mid_rst_err",     len_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_v", pkt_v, 0);
    flit_v = 1'b1; flit_data = 16'h8001; step();
    flit_data = 16'h7777; step();
    flit_v = 1'b0;
    chk("p1_v",       pkt_v, 1);
    chk("p1_len",     len, 1);
    chk("p1_payload", payload, 64'h7777);
    chk("p1_hdr",     hdr, 16'h8001);
    pkt_ready = 1'b1; step(); pkt_ready = 1'b0;

    // Random gaps on both sides against a scoreboard.
    for (int i = 0; i < 1000; i++) begin
      int n;
      n = $urandom_range(0, M);
      e.h = W'($urandom) & 16'hFFF8 | W'(n);
      e.n = L'(n);
      e.p = '0;
      flit_q.push_back(e.h);
      for (int k = 0; k < n; k++) begin
        logic [W-1:0] f;
        f = W'($urandom);
        e.p[k*W +: W] = f;
        flit_q.push_back(f);
      end
      exp_q.push_back(e);
    end
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 40000) begin
      flit_v    = (flit_q.size() > 0) && ($urandom_range(0, 3) != 0);
      flit_data = (flit_q.size() > 0) ? flit_q[0] : '0;
      pkt_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      fhs = flit_v & flit_ready;
      phs = pkt_v & pkt_ready;
      if (fhs) void'(flit_q.pop_front());
      if (phs) begin
        e = exp_q.pop_front();
        chk("sb_hdr",     hdr, e.h);
        chk("sb_len",     len, e.n);
        chk("sb_payload", payload, e.p);
      end
      step();
      cyc++;
    end
    flit_v = 1'b0; pkt_ready = 1'b0;
    chk("sb_drained", exp_q.size(), 0);
    step();
    chk("sb_no_extra", pkt_v, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/bsg_sdr_link_packet_assembler.md
Name: bsg_sdr_link_packet_assembler

Overview:
- Sits directly downstream of the SDR link pearl's core-side receive port (core_data_o/core_v_o/core_ready_and_i).
- Reassembles the narrow flit stream into whole packets: one header flit followed by N payload flits, where N is taken from the header.
- Presents each complete packet, zero-padded, on a wide ready/valid interface to the core.
- Single-entry buffered, so back-pressure propagates to the link FIFO through ready_and_o.

Parameters:
- flit_width_p, 16, flit width; equals the pearl's sdr_data_width_p.
- max_payload_flits_p, 4, maximum payload flits per packet; must be >= 1.
- len_width_p, `BSG_SAFE_CLOG2(max_payload_flits_p+1), width of the length field in header bits [len_width_p-1:0]; must be < flit_width_p.

Ports:
- core_clk_i, in, 1, sole clock.
- core_reset_n_i, in, 1, reset; asynchronous, active-low.
- flit_data_i, in, flit_width_p, incoming flit from the pearl's core_data_o.
- flit_v_i, in, 1, flit valid.
- flit_ready_and_o, out, 1, flit accepted when flit_v_i & flit_ready_and_o.
- pkt_header_o, out, flit_width_p, captured header flit.
- pkt_payload_o, out, max_payload_flits_p*flit_width_p, payload; flit k occupies bits [k*flit_width_p +: flit_width_p].
- pkt_len_o, out, len_width_p, number of valid payload flits (clamped).
- pkt_v_o, out, 1, packet valid.
- pkt_ready_and_i, in, 1, packet consumed when pkt_v_o & pkt_ready_and_i.
- len_err_o, out, 1, sticky; set when a header length exceeds max_payload_flits_p.

Behaviour:
- Reset (asynchronous assert, synchronous-style release on the clock):
  - state=IDLE; all outputs 0.
  - Payload and header registers cleared.
  - len_err_o cleared.
- States: IDLE (awaiting header), BODY (collecting payload), DONE (holding packet).
- flit_ready_and_o = (state != DONE); registered state only, no combinational path from pkt_ready_and_i.
- pkt_v_o = (state == DONE).
- IDLE, on flit handshake:
  - Capture header.
  - len = header[len_width_p-1:0].
  - If len > max_payload_flits_p: set len_err_o and clamp the stored len to max_payload_flits_p.
  - Clear the payload register to 0 and reset the flit counter to 0.
  - Next state: DONE if len==0, else BODY.
- BODY, on flit handshake:
  - Write the flit into slot cnt; cnt++.
  - When cnt+1 == stored len, go to DONE next cycle.
  - An unaccepted flit (flit_v_i=0) holds all state.
- Header with an over-max length:
  - Payload flits beyond the clamped length are not part of this packet and are not consumed by it.
  - The next flit is interpreted as a new header.
  - Resynchronisation after this is the sender's responsibility; len_err_o flags the event.
- DONE:
  - Outputs stable until pkt_ready_and_i=1, then IDLE next cycle.
  - Latency: header plus N payload handshakes in consecutive cycles gives pkt_v_o high on the cycle after the last flit.
  - Minimum packet period is N+2 cycles (one bubble for DONE).
- Counter width: `BSG_SAFE_CLOG2(max_payload_flits_p); it never wraps because the DONE transition occurs at cnt == len-1.
- Simultaneous events:
  - In DONE, an incoming flit_v_i is not accepted (ready low), even in the cycle pkt_ready_and_i is asserted.
- Reset mid-packet: the partial packet is discarded, state returns to IDLE, and no pkt_v_o pulse is produced.
- Payload slots at index >= pkt_len_o read as 0.
- len_err_o clears only on reset.

Decomposition:
- bsg_link_pearl_pkg gains:
  - The state enum bsg_sdr_link_pkt_asm_state_e (IDLE/BODY/DONE, 2 bits).
  - A helper localparam for the header length-field position.
- No sub-module: one FSM, one counter, and one write-enabled payload register array in a single module.
- Standard bsg_dff_reset_en-style primitives may be instantiated for the registers.

Test Plan (flit_width_p=16, max_payload_flits_p=4, len_width_p=3):
- Header 16'hA003, then 16'h1111, 16'h2222, 16'h3333 back-to-back:
  - pkt_v_o rises one cycle after the last flit.
  - pkt_len_o=3, payload={16'h0,16'h3333,16'h2222,16'h1111}, header=16'hA003.
- Header 16'h0000 (len 0): pkt_v_o=1 the next cycle, pkt_len_o=0, payload all 0.
- Complete packet held with pkt_ready_and_i=0 for 5 cycles while flit_v_i=1:
  - flit_ready_and_o=0 throughout and outputs stable.
  - Assert pkt_ready_and_i: IDLE next cycle, then the next header is accepted.
- Header 16'h0007 (len 7 > 4):
  - len_err_o=1 and pkt_len_o=4 after 4 payload flits.
  - The fifth flit is taken as a new header.
- Header len 2, one payload flit, then core_reset_n_i pulsed low asynchronously mid-cycle:
  - All outputs go to 0 immediately and no packet is emitted.
  - A subsequent len-1 packet assembles correctly.
- Random flit_v_i/pkt_ready_and_i gaps over 1000 packets versus a scoreboard: no loss, duplication or reordering.
